// File: rtl/zet_rep_pkg.sv
// Shared types and constants for the REP string-instruction sequencer.
// Opcodes are stored as opcode[7:1]; bit 0 (byte/word) never affects sequencing.
package zet_rep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    FIN,
    INTR
  } rep_state_t;

  localparam logic [6:0] OP_MOVS = 7'b1010_010;
  localparam logic [6:0] OP_CMPS = 7'b1010_011;
  localparam logic [6:0] OP_STOS = 7'b1010_101;
  localparam logic [6:0] OP_LODS = 7'b1010_110;
  localparam logic [6:0] OP_SCAS = 7'b1010_111;
  localparam logic [6:0] OP_INS  = 7'b0110_110;
  localparam logic [6:0] OP_OUTS = 7'b0110_111;

  localparam int PFX_REP = 1;
  localparam int PFX_Z   = 0;

  function automatic logic is_string_op(input logic [6:0] op);
    return (op == OP_MOVS) || (op == OP_CMPS) || (op == OP_STOS) ||
           (op == OP_LODS) || (op == OP_SCAS) || (op == OP_INS)  ||
           (op == OP_OUTS);
  endfunction

endpackage

// File: rtl/zet_rep_exit_eval.sv
// Combinational termination check for one REP iteration: CX exhaustion or ZF condition.
// Also classifies the opcode as a string op eligible for repetition.
module zet_rep_exit_eval
  import zet_rep_pkg::*;
(
  input  logic [1:0] prefix,
  input  logic [6:0] opcode,
  input  logic       zf,
  input  logic       cnt_next_zero,
  output logic       valid_op,
  output logic       exit_rep
);

  logic cmp_sca;
  logic exit_z;

  assign valid_op = is_string_op(opcode);

  // CMPS/SCAS are the only ops whose flags can end the loop early
  assign cmp_sca = opcode[6] & opcode[1] & opcode[0];

  // ZF termination only exists under a rep prefix; repz leaves on ZF=0, repnz on ZF=1
  assign exit_z   = prefix[PFX_REP] & cmp_sca & (prefix[PFX_Z] ? ~zf : zf);
  assign exit_rep = cnt_next_zero | exit_z;

endmodule

// File: rtl/zet_rep_sequencer.sv
// Sequences REP/REPZ/REPNZ string ops: one exec iteration at a time, CX countdown, exit on CX/ZF/interrupt.
// All outputs come from registers or the state register; CX write precedes the next iter_go by one cycle.
module zet_rep_sequencer
  import zet_rep_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       prefix,
  input  logic [6:0]       opcode,
  input  logic [CNT_W-1:0] cx_in,
  input  logic             iter_done,
  input  logic             zf,
  input  logic             ext_int,
  output logic             iter_go,
  output logic [CNT_W-1:0] cx_out,
  output logic             cx_we,
  output logic             busy,
  output logic             done,
  output logic             int_exit
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  rep_state_t       state;
  rep_state_t       state_nxt;
  logic [1:0]       prefix_q;
  logic [6:0]       opcode_q;
  logic [CNT_W-1:0] cnt;
  logic             rep_q;

  logic             idle;
  logic [1:0]       eval_prefix;
  logic [6:0]       eval_opcode;
  logic [CNT_W-1:0] cnt_dec;
  logic             cnt_next_zero;
  logic             valid_op;
  logic             exit_rep;
  logic             rep_start;

  assign idle = (state == IDLE);

  // The evaluator looks at the incoming instruction while idle, the latched one afterwards
  assign eval_prefix   = idle ? prefix : prefix_q;
  assign eval_opcode   = idle ? opcode : opcode_q;
  assign cnt_dec       = cnt - CNT_ONE;
  assign cnt_next_zero = (cnt_dec == '0);
  assign rep_start     = prefix[PFX_REP] & valid_op;

  zet_rep_exit_eval u_exit_eval (
    .prefix        (eval_prefix),
    .opcode        (eval_opcode),
    .zf            (zf),
    .cnt_next_zero (cnt_next_zero),
    .valid_op      (valid_op),
    .exit_rep      (exit_rep)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (rep_start && (cx_in == '0)) ? FIN : ISSUE;
        end
      end
      ISSUE: begin
        // Hold one extra cycle while the decremented CX is being written back
        if (!cx_we) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (iter_done) begin
          if (!rep_q || exit_rep) begin
            state_nxt = FIN;
          end else if (ext_int) begin
            state_nxt = INTR;
          end else begin
            state_nxt = ISSUE;
          end
        end
      end
      FIN:     state_nxt = IDLE;
      INTR:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    iter_go  = (state == ISSUE) & ~cx_we;
    busy     = (state != IDLE);
    done     = (state == FIN);
    int_exit = (state == INTR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prefix_q <= '0;
      opcode_q <= '0;
      cnt      <= '0;
      rep_q    <= 1'b0;
      cx_out   <= '0;
      cx_we    <= 1'b0;
    end else begin
      cx_we <= 1'b0;
      if (idle && start) begin
        prefix_q <= prefix;
        opcode_q <= opcode;
        cnt      <= cx_in;
        rep_q    <= rep_start;
      end
      // Never reached with cnt==0: a zero count goes straight to FIN
      if ((state == WAIT) && iter_done && rep_q) begin
        cnt    <= cnt_dec;
        cx_out <= cnt_dec;
        cx_we  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_zet_rep_sequencer.sv
// Bench for zet_rep_sequencer: directed and random string instructions checked against a
// transaction-level model of iteration count, CX writes, exit kind and cycle timing.
module tb_zet_rep_sequencer;

  localparam int CNT_W = 16;

  localparam logic [6:0] MOVS = 7'b1010010;
  localparam logic [6:0] CMPS = 7'b1010011;
  localparam logic [6:0] STOS = 7'b1010101;
  localparam logic [6:0] LODS = 7'b1010110;
  localparam logic [6:0] SCAS = 7'b1010111;
  localparam logic [6:0] INS  = 7'b0110110;
  localparam logic [6:0] OUTS = 7'b0110111;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       prefix;
  logic [6:0]       opcode;
  logic [CNT_W-1:0] cx_in;
  logic             iter_done;
  logic             zf;
  logic             ext_int;
  logic             iter_go;
  logic [CNT_W-1:0] cx_out;
  logic             cx_we;
  logic             busy;
  logic             done;
  logic             int_exit;

  int n_tests = 0;
  int n_fail  = 0;

  bit zf_seq  [64];
  bit int_seq [64];
  int dly_fixed;
  bit noise_start;

  int          obs_go, obs_done, obs_int, obs_terr;
  bit          obs_to;
  logic [15:0] obs_cx[$];
  int          exp_go;
  bit          exp_int;
  logic [15:0] exp_cx[$];

  always #5 clk = ~clk;

  zet_rep_sequencer #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .prefix    (prefix),
    .opcode    (opcode),
    .cx_in     (cx_in),
    .iter_done (iter_done),
    .zf        (zf),
    .ext_int   (ext_int),
    .iter_go   (iter_go),
    .cx_out    (cx_out),
    .cx_we     (cx_we),
    .busy      (busy),
    .done      (done),
    .int_exit  (int_exit)
  );

  function automatic bit is_str(input logic [6:0] op);
    return op inside {MOVS, CMPS, STOS, LODS, SCAS, INS, OUTS};
  endfunction

  function automatic int seq_idx(input int n);
    return (n > 63) ? 63 : ((n < 0) ? 0 : n);
  endfunction

  // Reference: what the instruction does, iteration by iteration, ignoring cycles
  task automatic model(input logic [1:0] pfx, input logic [6:0] op, input int cx);
    int rem;
    bit rep, cmpsca, zstop;
    exp_cx.delete();
    exp_int = 0;
    exp_go  = 0;
    rep     = pfx[1] && is_str(op);
    cmpsca  = (op == CMPS) || (op == SCAS);
    if (!rep) begin
      exp_go = 1;
      return;
    end
    rem = cx;
    while (rem > 0) begin
      exp_go++;
      rem--;
      exp_cx.push_back(16'(rem));
      zstop = pfx[0] ? !zf_seq[seq_idx(exp_go-1)] : zf_seq[seq_idx(exp_go-1)];
      if (rem == 0 || (cmpsca && zstop)) break;
      if (int_seq[seq_idx(exp_go-1)]) begin
        exp_int = 1;
        break;
      end
    end
  endtask

  // Drives one instruction like the exec unit would and records what the DUT did
  task automatic run_txn(input logic [1:0] pfx, input logic [6:0] op, input logic [15:0] cx);
    int pend, last_p, end_c, d;
    obs_go = 0; obs_done = 0; obs_int = 0; obs_terr = 0; obs_to = 0;
    obs_cx.delete();
    @(negedge clk);
    start = 1; prefix = pfx; opcode = op; cx_in = cx; iter_done = 0;
    pend = -1; last_p = -1; end_c = -1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (end_c >= 0) begin
        if ({busy, iter_go, done, int_exit, cx_we} !== 5'b0) obs_terr++;
        start = 0; iter_done = 0; ext_int = 0;
        break;
      end
      if (busy !== 1'b1) obs_terr++;
      if (iter_go === 1'b1) begin
        obs_go++;
        if (c != ((obs_go == 1) ? 1 : last_p + 1)) obs_terr++;
        d = (dly_fixed > 0) ? dly_fixed : int'($urandom_range(1, 4));
        pend = c + d;
      end
      if (cx_we === 1'b1) begin
        obs_cx.push_back(cx_out);
        if (c != last_p) obs_terr++;
      end
      if (done === 1'b1) begin
        obs_done++;
        end_c = c;
        if (c != ((obs_go == 0) ? 1 : last_p)) obs_terr++;
      end
      if (int_exit === 1'b1) begin
        obs_int++;
        end_c = c;
        if (c != last_p) obs_terr++;
      end
      start     = noise_start && ($urandom_range(3) == 0);
      prefix    = 2'($urandom);
      opcode    = 7'($urandom);
      cx_in     = 16'($urandom);
      iter_done = 0;
      zf        = 1'($urandom);
      ext_int   = 1'($urandom);
      if (c == pend) begin
        iter_done = 1;
        zf        = zf_seq[seq_idx(obs_go-1)];
        ext_int   = int_seq[seq_idx(obs_go-1)];
        last_p    = c + 1;
        pend      = -1;
      end
    end
    obs_to = (end_c < 0);
    start = 0; iter_done = 0; ext_int = 0;
  endtask

  task automatic clear_seqs();
    for (int i = 0; i < 64; i++) begin
      zf_seq[i]  = 0;
      int_seq[i] = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1; start = 0; prefix = 0; opcode = 0; cx_in = 0;
    iter_done = 0; zf = 0; ext_int = 0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({iter_go, cx_we, busy, done, int_exit} !== 5'b0 || cx_out !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_hold outputs got %b cx_out %h want 00000 cx_out 0000",
               {iter_go, cx_we, busy, done, int_exit}, cx_out);
    end
    rst = 0;
    @(negedge clk);
    n_tests++;
    if ({iter_go, cx_we, busy, done, int_exit} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_release outputs got %b want 00000", {iter_go, cx_we, busy, done, int_exit});
    end
  endtask

  task automatic test_rep_basic();
    logic [1:0] pf[3] = '{2'b10, 2'b10, 2'b00};
    logic [6:0] oc[3] = '{MOVS, STOS, LODS};
    int         cv[3] = '{3, 0, 7};
    dly_fixed = 3; noise_start = 0;
    clear_seqs();
    for (int s = 0; s < 3; s++) begin
      model(pf[s], oc[s], cv[s]);
      run_txn(pf[s], oc[s], 16'(cv[s]));
      n_tests++; if (obs_to || obs_terr != 0) begin n_fail++; $display("FAIL basic%0d timing errors got %0d timeout %0d want 0", s, obs_terr, obs_to); end
      n_tests++; if (obs_go != exp_go) begin n_fail++; $display("FAIL basic%0d iter_go count got %0d want %0d", s, obs_go, exp_go); end
      n_tests++; if (obs_done != 1 || obs_int != 0) begin n_fail++; $display("FAIL basic%0d done/int_exit got %0d/%0d want 1/0", s, obs_done, obs_int); end
      n_tests++; if (obs_cx.size() != exp_cx.size()) begin n_fail++; $display("FAIL basic%0d cx_we count got %0d want %0d", s, obs_cx.size(), exp_cx.size()); end
      else foreach (exp_cx[i]) begin
        n_tests++; if (obs_cx[i] !== exp_cx[i]) begin n_fail++; $display("FAIL basic%0d cx_out[%0d] got %0d want %0d", s, i, obs_cx[i], exp_cx[i]); end
      end
    end
  endtask

  task automatic test_zf_exit();
    logic [1:0]  pf[3] = '{2'b11, 2'b10, 2'b11};
    logic [6:0]  oc[3] = '{CMPS, SCAS, CMPS};
    logic [15:0] cv[3] = '{16'd5, 16'd4, 16'h8000};
    dly_fixed = 0; noise_start = 0;
    for (int s = 0; s < 3; s++) begin
      clear_seqs();
      if (s == 1) zf_seq[2] = 1;
      if (s == 2) begin zf_seq[0] = 1; zf_seq[1] = 1; end
      model(pf[s], oc[s], int'(cv[s]));
      run_txn(pf[s], oc[s], cv[s]);
      n_tests++; if (obs_to || obs_terr != 0) begin n_fail++; $display("FAIL zf%0d timing errors got %0d timeout %0d want 0", s, obs_terr, obs_to); end
      n_tests++; if (obs_go != exp_go) begin n_fail++; $display("FAIL zf%0d iter_go count got %0d want %0d", s, obs_go, exp_go); end
      n_tests++; if (obs_done != 1 || obs_int != 0) begin n_fail++; $display("FAIL zf%0d done/int_exit got %0d/%0d want 1/0", s, obs_done, obs_int); end
      n_tests++; if (obs_cx.size() != exp_cx.size()) begin n_fail++; $display("FAIL zf%0d cx_we count got %0d want %0d", s, obs_cx.size(), exp_cx.size()); end
      else foreach (exp_cx[i]) begin
        n_tests++; if (obs_cx[i] !== exp_cx[i]) begin n_fail++; $display("FAIL zf%0d cx_out[%0d] got %h want %h", s, i, obs_cx[i], exp_cx[i]); end
      end
    end
  endtask

  task automatic test_interrupt();
    logic [6:0] oc[3] = '{MOVS, MOVS, STOS};
    int         cv[3] = '{4, 2, 5};
    int         at[3] = '{1, 1, 0};
    dly_fixed = 0; noise_start = 0;
    for (int s = 0; s < 3; s++) begin
      clear_seqs();
      int_seq[at[s]] = 1;
      model(2'b10, oc[s], cv[s]);
      run_txn(2'b10, oc[s], 16'(cv[s]));
      n_tests++; if (obs_to || obs_terr != 0) begin n_fail++; $display("FAIL int%0d timing errors got %0d timeout %0d want 0", s, obs_terr, obs_to); end
      n_tests++; if (obs_go != exp_go) begin n_fail++; $display("FAIL int%0d iter_go count got %0d want %0d", s, obs_go, exp_go); end
      n_tests++; if (obs_int != int'(exp_int) || obs_done != int'(!exp_int)) begin n_fail++; $display("FAIL int%0d int_exit/done got %0d/%0d want %0d/%0d", s, obs_int, obs_done, exp_int, !exp_int); end
      n_tests++; if (obs_cx.size() != exp_cx.size()) begin n_fail++; $display("FAIL int%0d cx_we count got %0d want %0d", s, obs_cx.size(), exp_cx.size()); end
      else foreach (exp_cx[i]) begin
        n_tests++; if (obs_cx[i] !== exp_cx[i]) begin n_fail++; $display("FAIL int%0d cx_out[%0d] got %0d want %0d", s, i, obs_cx[i], exp_cx[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    dly_fixed = 0; noise_start = 0;
    clear_seqs();
    @(negedge clk);
    start = 1; prefix = 2'b10; opcode = MOVS; cx_in = 16'd5;
    @(negedge clk);
    start = 0;
    n_tests++; if (iter_go !== 1'b1) begin n_fail++; $display("FAIL rstwait first iter_go got %b want 1", iter_go); end
    @(negedge clk);
    n_tests++; if ({busy, iter_go} !== 2'b10) begin n_fail++; $display("FAIL rstwait in_wait busy/iter_go got %b want 10", {busy, iter_go}); end
    rst = 1; iter_done = 1; ext_int = 1; zf = 1;
    @(negedge clk);
    rst = 0; iter_done = 0; ext_int = 0;
    n_tests++;
    if ({iter_go, cx_we, busy, done, int_exit} !== 5'b0 || cx_out !== 16'h0) begin
      n_fail++;
      $display("FAIL rstwait after_reset outputs got %b cx_out %h want 00000 cx_out 0000",
               {iter_go, cx_we, busy, done, int_exit}, cx_out);
    end
    @(negedge clk);
    n_tests++; if ({iter_go, cx_we, busy, done, int_exit} !== 5'b0) begin n_fail++; $display("FAIL rstwait quiet outputs got %b want 00000", {iter_go, cx_we, busy, done, int_exit}); end
    model(2'b10, MOVS, 2);
    run_txn(2'b10, MOVS, 16'd2);
    n_tests++; if (obs_to || obs_terr != 0) begin n_fail++; $display("FAIL rstwait_after timing errors got %0d timeout %0d want 0", obs_terr, obs_to); end
    n_tests++; if (obs_go != exp_go || obs_done != 1) begin n_fail++; $display("FAIL rstwait_after go/done got %0d/%0d want %0d/1", obs_go, obs_done, exp_go); end
    n_tests++; if (obs_cx.size() != 2 || obs_cx[obs_cx.size()-1] !== 16'd0) begin n_fail++; $display("FAIL rstwait_after cx writes got %0d want 2 ending at 0", obs_cx.size()); end
  endtask

  task automatic test_random();
    logic [1:0] pf;
    logic [6:0] oc;
    int         cx;
    logic [6:0] ops[7] = '{MOVS, CMPS, STOS, LODS, SCAS, INS, OUTS};
    dly_fixed = 0; noise_start = 1;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 64; i++) begin
        zf_seq[i]  = 1'($urandom);
        int_seq[i] = ($urandom_range(3) == 0);
      end
      pf = 2'($urandom);
      oc = ($urandom_range(3) == 0) ? 7'($urandom) : ops[$urandom_range(6)];
      cx = int'($urandom_range(0, 9));
      model(pf, oc, cx);
      run_txn(pf, oc, 16'(cx));
      n_tests++;
      if (obs_to || obs_terr != 0 || obs_go != exp_go || obs_int != int'(exp_int) ||
          obs_done != int'(!exp_int) || obs_cx != exp_cx) begin
        n_fail++;
        $display("FAIL rand%0d pfx=%b op=%b cx=%0d got go=%0d done=%0d int=%0d nwr=%0d terr=%0d to=%0d want go=%0d done=%0d int=%0d nwr=%0d",
                 t, pf, oc, cx, obs_go, obs_done, obs_int, obs_cx.size(), obs_terr, obs_to,
                 exp_go, !exp_int, exp_int, exp_cx.size());
      end
    end
    noise_start = 0;
  endtask

  initial begin
    test_reset();
    test_rep_basic();
    test_zf_exit();
    test_interrupt();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/zet_rep_sequencer.md
Name: zet_rep_sequencer

Overview:
Controller that sequences REP/REPZ/REPNZ string instructions (MOVS, CMPS, STOS, LODS, SCAS, INS, OUTS) through the execution datapath.
- Latches prefix, opcode and CX at instruction start.
- Issues one execution iteration at a time and counts CX down.
- Evaluates the termination conditions: CX exhausted, the ZF condition for CMPS/SCAS, and a pending external interrupt.
- Signals retirement or interrupt suspension to the fetch logic.
- Sits between the decoder/fetch FSM and the exec unit.

Parameters:
CNT_W, 16, width of the CX counter

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
start  in  1  decoded string instruction ready; single-cycle pulse
prefix  in  2  [1]=rep present, [0]=1 repz / 0 repnz
opcode  in  7  opcode[7:1]
cx_in  in  CNT_W  CX value at start
iter_done  in  1  exec unit finished current iteration; pulse
zf  in  1  zero flag produced by the finishing iteration; valid with iter_done
ext_int  in  1  external interrupt pending (level)
iter_go  out  1  start one iteration; one-cycle pulse
cx_out  out  CNT_W  updated CX value
cx_we  out  1  write cx_out to CX register; one-cycle pulse
busy  out  1  instruction in progress
done  out  1  instruction retired, fetch next opcode; one-cycle pulse
int_exit  out  1  suspended for interrupt, IP must point at prefix; one-cycle pulse

Behaviour:
- Reset: state=IDLE; all outputs 0; cx_out=0.
- Reset anywhere, including mid-WAIT, returns to IDLE with no done/int_exit pulse.
- valid_op: opcode ∈ {1010_010, 1010_011, 1010_101, 1010_110, 1010_111, 0110_110, 0110_111}.
- cmp_sca: opcode[7]&opcode[2]&opcode[1] (CMPS/SCAS).
- rep_mode = prefix[1] & valid_op. In non-rep mode the block runs exactly one iteration with no CX update.
- States: IDLE, ISSUE, WAIT, FIN, INTR.
- IDLE:
  - busy=0.
  - On start, latch prefix, opcode, cx_in into cnt, and rep_mode.
  - Next state: rep_mode & cx_in==0 → FIN (zero iterations); otherwise → ISSUE.
  - start while not IDLE is ignored.
- ISSUE: iter_go=1 for one cycle → WAIT. First iter_go occurs the cycle after start.
- WAIT:
  - Hold until iter_done. iter_done outside WAIT is ignored; the exec unit never asserts it in the same cycle as iter_go.
  - On iter_done in non-rep mode → FIN.
  - On iter_done in rep mode:
    - cnt←cnt-1; cx_out←cnt-1; cx_we=1 on the following cycle (registered).
    - exit_z = cmp_sca & (prefix[0] ? ~zf : zf).
    - Priority: (cnt-1==0 | exit_z) → FIN; else ext_int → INTR; else → ISSUE.
    - CX exhaustion beats an interrupt taken in the same cycle.
  - Next iter_go is 2 cycles after iter_done (WAIT→ISSUE, then pulse).
- FIN: done=1 for one cycle → IDLE.
- INTR: int_exit=1 for one cycle → IDLE. CX already written, so re-execution resumes with the remaining count.
- busy=1 in every state except IDLE.
- Arithmetic: the decrement is never applied at cnt==0, because rep mode does not enter ISSUE with cnt==0. No wrap-around.
- ext_int is sampled only on iter_done in rep mode. Non-rep instructions are never interrupted mid-instruction.
- Outputs are registered or decoded directly from the state register; no combinational path from inputs to outputs.

Decomposition:
- Package zet_rep_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, FIN, INTR);
  - opcode[7:1] localparams for the seven string ops;
  - prefix bit index constants.
- One combinational sub-module, zet_rep_exit_eval:
  - inputs: prefix, opcode, zf, cnt_next_zero;
  - outputs: valid_op, exit_rep.
- The FSM and counter live in zet_rep_sequencer.

Test Plan:
- REP MOVSB (prefix=10, opcode=1010_010), cx_in=3, iter_done 3 cycles after each iter_go → 3 iter_go; cx_out 2,1,0 with cx_we; done once; busy deasserts the cycle after done.
- REP STOS, cx_in=0 → no iter_go, no cx_we; done the cycle after start.
- REPZ CMPSB (prefix=11, opcode=1010_011), cx_in=5, zf=0 on first iter_done → exactly one iter_go; cx_out=4; done.
- REPNZ SCAS (prefix=10, opcode=1010_111), cx_in=4, zf=0,0,1 → 3 iterations, cx_out ends at 1, done.
- REP MOVS, cx_in=4, ext_int raised during 2nd iteration → int_exit after 2nd iter_done with cx_out=2, no done. Repeat with cx_in=2: done wins, no int_exit.
- Non-rep LODS (prefix=00): one iter_go, no cx_we, done. Separately, rst asserted in WAIT: all outputs 0 and state IDLE next cycle, and a later start behaves normally.
